// File: rtl/pi_loop_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pi_loop_sequencer: loop tick, setpoint ramp/trim, PI hold and OVP latch.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pi_loop_sequencer #(
  parameter int TICK_DIV  = 100,
  parameter int VO_TARGET = 3430,
  parameter int VO_MIN    = 2000,
  parameter int VO_MAX    = 4000,
  parameter int VO_STEP   = 5,
  parameter int RAMP_STEP = 2,
  parameter int OVP_LIMIT = 4050,
  parameter int OVP_COUNT = 4
) (
  input  logic               i_clk_50mhz,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_key_add,
  input  logic               i_key_sub,
  input  logic               i_fault_clr,
  input  logic signed [12:0] i_vo,
  input  logic               i_vo_valid,
  output logic               o_loop_tick,
  output logic signed [12:0] o_vo_goal,
  output logic               o_pi_rst,
  output logic               o_drive_en,
  output logic               o_fault,
  output logic [1:0]         o_state
);

  localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_cnt_w  = $clog2(OVP_COUNT + 1);

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_cnt_w-1:0]  c_ovp_full  = c_cnt_w'(OVP_COUNT);

  localparam logic signed [12:0] c_vo_target = 13'(VO_TARGET);
  localparam logic signed [12:0] c_ovp_limit = 13'(OVP_LIMIT);
  localparam logic signed [13:0] c_vo_min    = 14'(VO_MIN);
  localparam logic signed [13:0] c_vo_max    = 14'(VO_MAX);
  localparam logic signed [13:0] c_vo_step   = 14'(VO_STEP);
  localparam logic signed [13:0] c_ramp_step = 14'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SOFTSTART = 2'd1,
    ST_REGULATE  = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_tick_w-1:0]   r_tick_cnt;
  logic                  w_tick;
  logic signed [12:0]    r_vo_q;
  logic signed [12:0]    r_user_goal;
  logic signed [12:0]    r_vo_goal;
  logic signed [12:0]    w_user_goal_next;
  logic signed [12:0]    w_vo_goal_next;
  logic                  r_add_prev;
  logic                  r_sub_prev;
  logic                  w_add_edge;
  logic                  w_sub_edge;
  logic [c_cnt_w-1:0]    r_ovp_cnt;
  logic [c_cnt_w-1:0]    w_ovp_cnt_next;
  logic                  w_active;
  logic                  w_ovp_trip;
  logic signed [13:0]    w_user_ext;
  logic signed [13:0]    w_goal_ext;
  logic signed [13:0]    w_user_sum;
  logic signed [13:0]    w_ramp_sum;

  assign w_tick     = (r_tick_cnt == c_tick_last);
  assign w_add_edge = i_key_add & ~r_add_prev;
  assign w_sub_edge = i_key_sub & ~r_sub_prev;
  assign w_active   = (r_state == ST_SOFTSTART) || (r_state == ST_REGULATE);
  assign w_user_ext = {r_user_goal[12], r_user_goal};
  assign w_goal_ext = {r_vo_goal[12], r_vo_goal};
  assign w_ramp_sum = w_goal_ext + c_ramp_step;

  // Sums are one bit wider than the setpoint so the clamp sees the true value.
  always_comb begin
    w_user_sum = w_user_ext;
    if (w_add_edge && !w_sub_edge) begin
      w_user_sum = w_user_ext + c_vo_step;
    end else if (w_sub_edge && !w_add_edge) begin
      w_user_sum = w_user_ext - c_vo_step;
    end
    if (w_user_sum > c_vo_max) begin
      w_user_goal_next = c_vo_max[12:0];
    end else if (w_user_sum < c_vo_min) begin
      w_user_goal_next = c_vo_min[12:0];
    end else begin
      w_user_goal_next = w_user_sum[12:0];
    end
  end

  always_comb begin
    w_ovp_cnt_next = r_ovp_cnt;
    if (!w_active) begin
      w_ovp_cnt_next = '0;
    end else if (w_tick) begin
      if (r_vo_q > c_ovp_limit) begin
        if (r_ovp_cnt != c_ovp_full) begin
          w_ovp_cnt_next = r_ovp_cnt + 1'b1;
        end
      end else begin
        w_ovp_cnt_next = '0;
      end
    end
  end

  // Trip is decided on the tick itself so it outranks a concurrent stop.
  assign w_ovp_trip = w_active && w_tick && (w_ovp_cnt_next == c_ovp_full);

  always_comb begin
    w_state_next   = r_state;
    w_vo_goal_next = r_vo_goal;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          w_state_next = ST_SOFTSTART;
        end
      end
      ST_SOFTSTART: begin
        if (w_ovp_trip) begin
          w_state_next = ST_FAULT;
        end else if (i_stop) begin
          w_state_next = ST_IDLE;
        end else if (r_user_goal <= r_vo_goal) begin
          w_vo_goal_next = r_user_goal;
          w_state_next   = ST_REGULATE;
        end else if (w_tick) begin
          w_vo_goal_next = (w_ramp_sum > w_user_ext) ? r_user_goal : w_ramp_sum[12:0];
        end
      end
      ST_REGULATE: begin
        if (w_ovp_trip) begin
          w_state_next = ST_FAULT;
        end else if (i_stop) begin
          w_state_next = ST_IDLE;
        end else begin
          w_vo_goal_next = r_user_goal;
        end
      end
      ST_FAULT: begin
        if (i_fault_clr) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if ((w_state_next == ST_IDLE) || (w_state_next == ST_FAULT)) begin
      w_vo_goal_next = '0;
    end
  end

  always_ff @(posedge i_clk_50mhz) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_vo_q      <= '0;
      r_user_goal <= c_vo_target;
      r_vo_goal   <= '0;
      r_add_prev  <= 1'b0;
      r_sub_prev  <= 1'b0;
      r_ovp_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (i_vo_valid) begin
        r_vo_q <= i_vo;
      end
      r_user_goal <= w_user_goal_next;
      r_vo_goal   <= w_vo_goal_next;
      r_add_prev  <= i_key_add;
      r_sub_prev  <= i_key_sub;
      r_ovp_cnt   <= w_ovp_cnt_next;
    end
  end

  assign o_loop_tick = w_tick;
  assign o_vo_goal   = r_vo_goal;
  assign o_pi_rst    = (r_state == ST_IDLE) || (r_state == ST_FAULT);
  assign o_drive_en  = (r_state == ST_SOFTSTART) || (r_state == ST_REGULATE);
  assign o_fault     = (r_state == ST_FAULT);
  assign o_state     = r_state;

endmodule
`default_nettype wire
